// File: rtl/net_router_pkg.sv
// net_router_pkg: shared router constants and a mod-3 pointer increment.
package net_router_pkg;
  localparam int NUM_ROUTER_INPUTS = 3;
  localparam int PORT_PREV = 0;
  localparam int PORT_TERM = 1;
  localparam int PORT_NEXT = 2;
  function automatic logic [1:0] inc3(input logic [1:0] x);
    return (x == 2'd2) ? 2'd0 : x + 2'd1;
  endfunction
endpackage

// File: rtl/net_rr_arb3.sv
// net_rr_arb3: 3-way round-robin arbiter; priority moves past the winner on en.
module net_rr_arb3
  import net_router_pkg::*;
(
  input  logic       clk,
  input  logic       reset,
  input  logic [2:0] req,
  input  logic       en,
  output logic [2:0] gnt,
  output logic [1:0] win
);
  logic [1:0] r_ptr, w_c1, w_c2;
  always_comb begin
    w_c1 = inc3(r_ptr);
    w_c2 = inc3(w_c1);
    win  = req[r_ptr] ? r_ptr : req[w_c1] ? w_c1 : w_c2;
    gnt  = (|req) ? 3'd1 << win : 3'd0;
  end
  always_ff @(posedge clk)
    if (!reset) r_ptr <= 2'd0;
    else if (en) r_ptr <= inc3(win);
endmodule

// File: rtl/net_router_switch_arb.sv
// net_router_switch_arb: round-robin output arbiter feeding a 2-entry queue.
module net_router_switch_arb
  import net_router_pkg::*;
#(
  parameter int p_msg_nbits = 44,
  parameter int p_num_reqs  = NUM_ROUTER_INPUTS
) (
  input  logic                   clk,
  input  logic                   reset,
  input  logic [p_msg_nbits-1:0] istream_msg [p_num_reqs],
  input  logic                   istream_val [p_num_reqs],
  output logic                   istream_rdy [p_num_reqs],
  output logic [p_msg_nbits-1:0] ostream_msg,
  output logic                   ostream_val,
  input  logic                   ostream_rdy
);
  logic [p_msg_nbits-1:0] r_q [2];
  logic       r_head, r_tail;
  logic [1:0] r_cnt;
  logic [2:0] w_req, w_gnt;
  logic [1:0] w_win;
  logic       w_space, w_enq, w_deq;
  assign ostream_val = r_cnt != 2'd0;
  assign ostream_msg = r_q[r_head];
  // A full queue still accepts when the head leaves in the same cycle.
  always_comb begin
    for (int i = 0; i < 3; i++) w_req[i] = istream_val[i];
    w_space = (r_cnt < 2'd2) | ((r_cnt == 2'd2) & ostream_rdy);
    w_enq   = (|w_req) & w_space;
    w_deq   = ostream_val & ostream_rdy;
    for (int i = 0; i < 3; i++) istream_rdy[i] = w_gnt[i] & w_space;
  end
  net_rr_arb3 u_arb (
    .clk  (clk),
    .reset(reset),
    .req  (w_req),
    .en   (w_enq),
    .gnt  (w_gnt),
    .win  (w_win)
  );
  always_ff @(posedge clk)
    if (!reset) begin
      r_head <= 1'b0;
      r_tail <= 1'b0;
      r_cnt  <= 2'd0;
    end else begin
      if (w_enq) begin
        r_q[r_tail] <= istream_msg[w_win];
        r_tail      <= ~r_tail;
      end
      if (w_deq) r_head <= ~r_head;
      r_cnt <= r_cnt + 2'(w_enq) - 2'(w_deq);
    end
endmodule

// File: tb/tb_net_router_switch_arb.sv
// tb_net_router_switch_arb: directed and random checks of the switch arbiter.
module tb_net_router_switch_arb;
  logic        clk = 1'b0;
  logic        reset = 1'b0;
  logic [43:0] msg [3];
  logic        val [3];
  logic        rdy [3];
  logic [43:0] omsg;
  logic        oval;
  logic        ordy = 1'b0;
  int          checks = 0;
  int          errors = 0;

  always #5 clk = ~clk;

  net_router_switch_arb dut (
    .clk        (clk),
    .reset      (reset),
    .istream_msg(msg),
    .istream_val(val),
    .istream_rdy(rdy),
    .ostream_msg(omsg),
    .ostream_val(oval),
    .ostream_rdy(ordy)
  );

  function automatic logic [2:0] pk();
    return {rdy[2], rdy[1], rdy[0]};
  endfunction

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic setv(input logic [2:0] v);
    for (int i = 0; i < 3; i++) val[i] = v[i];
  endtask

  task automatic do_reset();
    setv(3'b000);
    ordy  = 1'b0;
    reset = 1'b0;
    tick();
    tick();
    reset = 1'b1;
  endtask

  task automatic test_reset();
    setv(3'b000);
    reset = 1'b0;
    tick();
    tick();
    checks++;
    if (oval !== 1'b0) begin errors++; $display("FAIL reset_oval got %b want 0", oval); end
    checks++;
    if (pk() !== 3'b000) begin errors++; $display("FAIL reset_rdy got %b want 000", pk()); end
    reset = 1'b1;
    tick();
    checks++;
    if (oval !== 1'b0) begin errors++; $display("FAIL post_reset_oval got %b want 0", oval); end
  endtask

  task automatic test_single();
    do_reset();
    msg[1] = 44'h1_0000_00AB;
    setv(3'b010);
    #1;
    checks++;
    if (pk() !== 3'b010) begin errors++; $display("FAIL single_rdy got %b want 010", pk()); end
    tick();
    setv(3'b000);
    #1;
    checks++;
    if (oval !== 1'b1) begin errors++; $display("FAIL single_oval got %b want 1", oval); end
    checks++;
    if (omsg !== 44'h1_0000_00AB) begin errors++; $display("FAIL single_msg got %h want 100000000ab", omsg); end
    ordy = 1'b1;
    tick();
    checks++;
    if (oval !== 1'b0) begin errors++; $display("FAIL single_drain got %b want 0", oval); end
  endtask

  task automatic test_round_robin();
    logic [43:0] m [3];
    m[0] = 44'hA0; m[1] = 44'hB1; m[2] = 44'hC2;
    do_reset();
    ordy = 1'b1;
    for (int k = 0; k < 6; k++) begin
      for (int i = 0; i < 3; i++) msg[i] = m[i];
      setv(3'b111);
      #1;
      checks++;
      if (pk() !== 3'd1 << (k % 3)) begin errors++; $display("FAIL rr_grant k=%0d got %b want %b", k, pk(), 3'd1 << (k % 3)); end
      tick();
      checks++;
      if (oval !== 1'b1 || omsg !== m[k % 3]) begin errors++; $display("FAIL rr_out k=%0d got %b/%h want 1/%h", k, oval, omsg, m[k % 3]); end
    end
  endtask

  task automatic test_backpressure();
    do_reset();
    msg[0] = 44'h100; msg[2] = 44'h302;
    setv(3'b101);
    #1;
    checks++;
    if (pk() !== 3'b001) begin errors++; $display("FAIL bp_first got %b want 001", pk()); end
    tick();
    checks++;
    if (pk() !== 3'b100) begin errors++; $display("FAIL bp_second got %b want 100", pk()); end
    tick();
    for (int k = 0; k < 2; k++) begin
      checks++;
      if (pk() !== 3'b000) begin errors++; $display("FAIL bp_full k=%0d got %b want 000", k, pk()); end
      tick();
    end
    checks++;
    if (omsg !== 44'h100) begin errors++; $display("FAIL bp_head got %h want 100", omsg); end
    msg[0] = 44'h101;
    ordy = 1'b1;
    #1;
    checks++;
    if (pk() !== 3'b001) begin errors++; $display("FAIL bp_blocked_winner got %b want 001", pk()); end
    tick();
    checks++;
    if (oval !== 1'b1 || omsg !== 44'h302) begin errors++; $display("FAIL bp_deq_enq got %b/%h want 1/302", oval, omsg); end
  endtask

  task automatic test_bypass();
    msg[1] = 44'h211;
    setv(3'b010);
    ordy = 1'b1;
    #1;
    checks++;
    if (pk() !== 3'b010) begin errors++; $display("FAIL bypass_rdy got %b want 010", pk()); end
    tick();
    ordy = 1'b0;
    setv(3'b001);
    #1;
    checks++;
    if (pk() !== 3'b000) begin errors++; $display("FAIL bypass_still_full got %b want 000", pk()); end
    checks++;
    if (omsg !== 44'h101) begin errors++; $display("FAIL bypass_head got %h want 101", omsg); end
    setv(3'b000);
    ordy = 1'b1;
    tick();
    checks++;
    if (oval !== 1'b1 || omsg !== 44'h211) begin errors++; $display("FAIL bypass_order got %b/%h want 1/211", oval, omsg); end
    tick();
    checks++;
    if (oval !== 1'b0) begin errors++; $display("FAIL bypass_empty got %b want 0", oval); end
  endtask

  task automatic test_mid_reset();
    do_reset();
    msg[0] = 44'h0_1234;
    setv(3'b001);
    tick();
    setv(3'b000);
    checks++;
    if (oval !== 1'b1) begin errors++; $display("FAIL mid_queued got %b want 1", oval); end
    reset = 1'b0;
    tick();
    reset = 1'b1;
    checks++;
    if (oval !== 1'b0) begin errors++; $display("FAIL mid_reset_oval got %b want 0", oval); end
    setv(3'b111);
    #1;
    checks++;
    if (pk() !== 3'b001) begin errors++; $display("FAIL mid_reset_ptr got %b want 001", pk()); end
    tick();
    setv(3'b000);
  endtask

  task automatic test_random();
    logic [43:0] q [$];
    logic [41:0] seq = '0;
    logic [2:0]  held = '0;
    logic [2:0]  v, exp;
    int          p = 0, w;
    int          waitc [3] = '{0, 0, 0};
    bit          space, found;
    do_reset();
    for (int c = 0; c < 10000; c++) begin
      for (int i = 0; i < 3; i++)
        if (!held[i]) begin
          v[i] = 1'($urandom_range(0, 1));
          if (v[i]) begin msg[i] = {2'(i), seq}; seq++; end
        end
      setv(v);
      ordy = $urandom_range(0, 3) != 0;
      #1;
      space = q.size() < 2 || (q.size() == 2 && ordy);
      found = 1'b0;
      w = 0;
      for (int k = 2; k >= 0; k--)
        if (v[(p + k) % 3]) begin found = 1'b1; w = (p + k) % 3; end
      exp = (found && space) ? 3'd1 << w : 3'd0;
      checks++;
      if (pk() !== exp) begin errors++; $display("FAIL rnd_grant c=%0d got %b want %b", c, pk(), exp); end
      checks++;
      if (oval !== (q.size() != 0)) begin errors++; $display("FAIL rnd_oval c=%0d got %b want %b", c, oval, q.size() != 0); end
      if (q.size() != 0) begin
        checks++;
        if (omsg !== q[0]) begin errors++; $display("FAIL rnd_msg c=%0d got %h want %h", c, omsg, q[0]); end
      end
      if (q.size() != 0 && ordy) void'(q.pop_front());
      if (exp != 3'd0) begin
        q.push_back(msg[w]);
        p = (w + 1) % 3;
        for (int i = 0; i < 3; i++)
          if (i == w || !v[i]) waitc[i] = 0;
          else begin
            waitc[i]++;
            checks++;
            if (waitc[i] > 2) begin errors++; $display("FAIL rnd_starve c=%0d req=%0d waited %0d want <=2", c, i, waitc[i]); end
          end
      end
      held = v & ~exp;
      tick();
    end
  endtask

  initial begin
    for (int i = 0; i < 3; i++) begin msg[i] = '0; val[i] = 1'b0; end
    #1;
    test_reset();
    test_single();
    test_round_robin();
    test_backpressure();
    test_bypass();
    test_mid_reset();
    test_random();
    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end
endmodule

// File: doc/net_router_switch_arb.md
Name: net_router_switch_arb

Overview:
- Output-side switch arbiter for one router output port in the 4-router ring network.
- Takes up to three competing input streams (from the route units of the three router inputs) and grants one per cycle using round-robin priority.
- Buffers each granted message in a 2-entry output queue, then drives the output channel, which is either the inter-router link or the terminal port.
- Single-phit messages: no multi-cycle grant locking.

Parameters:
- p_msg_nbits, 44, width of a network message (header plus payload).
- p_num_reqs, 3, number of requesting input streams; RTL is required to support only 3.

Ports:
- clk  input  1  clock.
- reset  input  1  synchronous, active-low reset: sampled on rising clk edge, block held in reset while 0.
- istream_msg  input  [p_msg_nbits-1:0] x3 (unpacked array [3])  message from requester i.
- istream_val  input  1 x3  requester i has a valid message.
- istream_rdy  output  1 x3  arbiter accepts requester i's message this cycle.
- ostream_msg  output  [p_msg_nbits-1:0]  head-of-queue message.
- ostream_val  output  1  queue non-empty.
- ostream_rdy  input  1  downstream accepts.

Behaviour:
- Reset state (reset==0 at a clk edge): queue count=0, head/tail pointers=0, priority pointer=0 (requester 0 highest, then 1, then 2).
  - Outputs during and after reset: ostream_val=0, istream_rdy all 0.
  - ostream_msg is don't-care when ostream_val=0; the bench must not check it.
- Space signal: space = (count<2) | (count==2 & ostream_rdy). Dequeue and enqueue are allowed in the same cycle when full.
- Arbitration is combinational.
  - Candidates are requesters with istream_val=1.
  - Search order starts at the priority pointer p: p, p+1, p+2 mod 3.
  - The first valid candidate is the winner.
- Grant: istream_rdy[w]=1 iff a winner exists and space=1; all other istream_rdy=0.
  - istream_rdy must not depend on other requesters' rdy. It may depend on all istream_val and on ostream_rdy.
- Transfer: istream_val[w] & istream_rdy[w] writes istream_msg[w] at the tail and advances tail mod 2.
- Priority update on a transfer only: p <= (w+1) mod 3. No transfer means p is unchanged, so a blocked winner keeps priority.
- Dequeue: ostream_val & ostream_rdy advances head mod 2.
- Count update: count += enq - deq. Simultaneous enq and deq when count==1 or 2 leaves count unchanged.
- Latency: a message accepted at edge N is visible on ostream at cycle N+1 when the queue was empty. Throughput is 1 msg/cycle.
- Ordering: messages leave in grant order. No message is dropped or duplicated.
- Fairness: with all 3 requesters continuously valid and ostream_rdy=1, grants cycle 0,1,2,0,… Any continuously valid requester is served within 3 transfers.
- Deassert of istream_val without a transfer: legal; no state change.
- Reset mid-operation: queue contents discarded, pointer returns to 0, ostream_val=0 the cycle after the reset edge.
- Line trace: per cycle, the granted requester index or '.', and the queue count.

Decomposition:
- Shared package net_router_pkg:
  - localparam NUM_ROUTER_INPUTS=3.
  - Port index constants: PORT_PREV=0, PORT_TERM=1, PORT_NEXT=2.
  - Header field macros come from the existing net-msgs include.
- Sub-module net_rr_arb3:
  - Contents: 3-way round-robin arbiter holding the priority register.
  - Inputs: req[3] and an en/update strobe.
  - Outputs: one-hot grant and the encoded winner.
- The 2-entry queue stays inline in net_router_switch_arb.

Test Plan:
- Reset, then single request: reset=0 for 2 cycles, then istream_val[1]=1 with msg=44'h1_0000_00AB → istream_rdy[1]=1 that cycle; next cycle ostream_val=1, ostream_msg=44'h1_0000_00AB.
- All three requesters valid with ostream_rdy=1, msgs A0/B1/C2 reloaded every cycle → output order 0,1,2,0,1,2 over 6 cycles, one per cycle.
- Backpressure: ostream_rdy=0, requesters 0 and 2 valid.
  - Two messages enqueued, then all istream_rdy=0 while full; pointer stays at the blocked winner (1st enq from 0, 2nd from 2, blocked winner 0).
  - Raise ostream_rdy → same-cycle deq+enq, count stays 2.
- Full-queue bypass: count==2, ostream_rdy=1, requester 1 valid → istream_rdy[1]=1; count remains 2 and order is preserved.
- Mid-stream reset: one queued message, assert reset=0 for one edge → ostream_val=0 next cycle; next grant with all valid goes to requester 0.
- Random stress: random val and rdy over 10k cycles.
  - Scoreboard confirms no loss, no duplication, grant-order output.
  - No requester waits more than 3 transfers while continuously valid.
